// File: rtl/alu_sequencer.sv
// Single-issue ALU sequencer: accepts an instruction, reads operands from an
// 8x16 register file, drives the ALU, waits for its result and writes it back.
module alu_sequencer #(
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned NREG    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic [15:0] instr_imm,
    output logic        alu_en_in,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_func,
    input  logic        alu_en_out,
    input  logic [15:0] alu_result,
    output logic        done,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned FW = 3;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            en_in_q, en_in_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [FW-1:0]   func_q, func_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   res_q, res_d;
    logic            done_q, done_d;
    logic [AW-1:0]   wb_addr_q, wb_addr_d;
    logic [DW-1:0]   wb_data_q, wb_data_d;
    logic            err_q, err_d;
    logic [DW-1:0]   regs_q [NREG];

    logic            accept_c;
    logic            timeout_c;
    logic            reg_we_c;
    logic [CW-1:0]   cnt_inc_c;
    logic [AW-1:0]   ra_c, rb_c;

    assign ra_c      = instr[9:7];
    assign rb_c      = instr[6:4];
    assign accept_c  = (state_q == IDLE) && instr_valid && ready_q;
    assign cnt_inc_c = cnt_q + CW'(1);
    assign timeout_c = (state_q == EXEC) && !alu_en_out && (cnt_inc_c == CW'(TIMEOUT));
    assign reg_we_c  = (state_q == WB) && (rd_q != '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept_c) state_d = EXEC;
            EXEC: begin
                if (alu_en_out)     state_d = WB;
                else if (timeout_c) state_d = IDLE;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        ready_d   = (state_d == IDLE);
        en_in_d   = (state_d == EXEC);
        a_d       = a_q;
        b_d       = b_q;
        func_d    = func_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        done_d    = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        err_d     = 1'b0;
        if (accept_c) begin
            func_d = instr[15:13];
            rd_d   = instr[12:10];
            a_d    = regs_q[ra_c];
            b_d    = instr[3] ? instr_imm : regs_q[rb_c];
            cnt_d  = '0;
        end
        if (state_q == EXEC) begin
            if (alu_en_out) begin
                res_d     = alu_result;
                done_d    = 1'b1;
                wb_addr_d = rd_q;
                wb_data_d = alu_result;
            end else begin
                cnt_d = cnt_inc_c;
                err_d = timeout_c;
            end
        end
    end

    // Datapath, output and register-file flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q   <= 1'b0;
            en_in_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            func_q    <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ready_q   <= ready_d;
            en_in_q   <= en_in_d;
            a_q       <= a_d;
            b_q       <= b_d;
            func_q    <= func_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            done_q    <= done_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
            if (reg_we_c) begin
                regs_q[rd_q] <= res_q;
            end
        end
    end

    assign instr_ready = ready_q;
    assign alu_en_in   = en_in_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_func    = func_q;
    assign done        = done_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign err         = err_q;
    assign dbg_data    = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU (immediate,
// never-responding and delayed response modes).
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [15:0] instr_imm = '0;
    logic        alu_en_in;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_func;
    logic        alu_en_out;
    logic [15:0] alu_result;
    logic        done;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        err;
    logic [2:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int alu_mode = 0;
    int alu_delay = 0;
    int dcnt = 0;

    typedef struct {
        bit          is_err;
        logic [2:0]  addr;
        logic [15:0] data;
        int          acc_cyc;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    alu_sequencer #(.TIMEOUT(8), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_imm(instr_imm),
        .alu_en_in(alu_en_in), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_en_out(alu_en_out), .alu_result(alu_result),
        .done(done), .wb_addr(wb_addr), .wb_data(wb_data), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU
    always_comb begin
        case (alu_func)
            3'd0:    alu_result = alu_b;
            3'd1:    alu_result = alu_a + alu_b;
            3'd2:    alu_result = alu_a - alu_b;
            3'd3:    alu_result = alu_a & alu_b;
            3'd4:    alu_result = alu_a | alu_b;
            3'd5:    alu_result = {alu_a[14:0], 1'b0};
            3'd6:    alu_result = {1'b0, alu_a[15:1]};
            default: alu_result = 16'h0000;
        endcase
    end
    assign alu_en_out = alu_en_in && ((alu_mode == 0) || (alu_mode == 2 && dcnt >= alu_delay));
    always @(posedge clk) dcnt <= alu_en_in ? dcnt + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done/err is matched against the scoreboard head
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got done=%0b err=%0b expected none", done, err);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_kind", {30'd0, err, done}, e.is_err ? 32'd2 : 32'd1);
                check("out_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                if (!e.is_err) begin
                    check("wb_addr", 32'(wb_addr), 32'(e.addr));
                    check("wb_data", 32'(wb_data), 32'(e.data));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic imm_sel, input logic [15:0] imm,
                         input logic [2:0] rsv, input logic [15:0] exp_data, input bit exp_err);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_wait: got instr_ready=0 expected 1 within 50 cycles");
        end
        instr       = {f, rd, ra, rb, imm_sel, rsv};
        instr_imm   = imm;
        instr_valid = 1'b1;
        e.is_err  = exp_err;
        e.addr    = rd;
        e.data    = exp_data;
        e.acc_cyc = cyc;
        e.lat     = exp_err ? 9 : 2;
        sb_q.push_back(e);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && instr_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0 || !instr_ready) begin
            checks++;
            failures++;
            $display("FAIL idle_wait: got pending=%0d ready=%0b expected 0 and 1", sb_q.size(), instr_ready);
            sb_q.delete();
        end
    endtask

    task automatic check_reg(input logic [2:0] a, input logic [15:0] exp);
        @(negedge clk);
        dbg_addr = a;
        #1;
        check($sformatf("r%0d", a), 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        int en_cnt;
        // Reset state
        #12;
        check("rst_ready", 32'(instr_ready), 0);
        check("rst_en_in", 32'(alu_en_in), 0);
        check("rst_outs", {alu_a, alu_b}, 0);
        check("rst_misc", {21'd0, alu_func, done, err, wb_addr}, 0);
        check("rst_wb_data", 32'(wb_data), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Load immediates (reserved bits set on the second)
        issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, 3'd0, 16'h1234, 0); wait_idle();
        issue(3'd0, 3'd2, 3'd5, 3'd6, 1'b1, 16'h00F0, 3'd7, 16'h00F0, 0); wait_idle();
        check_reg(3'd1, 16'h1234);
        check_reg(3'd2, 16'h00F0);

        // Register-register arithmetic, back-to-back dependent
        issue(3'd1, 3'd3, 3'd1, 3'd2, 1'b0, 16'hDEAD, 3'd0, 16'h1324, 0); wait_idle();
        issue(3'd2, 3'd4, 3'd2, 3'd1, 1'b0, 16'h0000, 3'd0, 16'hEEBC, 0); wait_idle();
        check_reg(3'd3, 16'h1324);
        check_reg(3'd4, 16'hEEBC);

        // Shifts and logic
        issue(3'd5, 3'd5, 3'd1, 3'd0, 1'b0, 16'h0000, 3'd0, 16'h2468, 0); wait_idle();
        issue(3'd6, 3'd6, 3'd2, 3'd0, 1'b0, 16'h0000, 3'd0, 16'h0078, 0); wait_idle();
        issue(3'd3, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 3'd0, 16'h0030, 0); wait_idle();
        check_reg(3'd5, 16'h2468);
        check_reg(3'd6, 16'h0078);
        check_reg(3'd7, 16'h0030);

        // r0 protection
        issue(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'hFFFF, 3'd0, 16'hFFFF, 0); wait_idle();
        check_reg(3'd0, 16'h0000);
        issue(3'd1, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000, 3'd0, 16'h0000, 0); wait_idle();
        check_reg(3'd1, 16'h0000);

        // OR then reserved func 111 (ALU returns 0, written normally)
        issue(3'd4, 3'd1, 3'd7, 3'd4, 1'b0, 16'h0000, 3'd0, 16'hEEBC, 0); wait_idle();
        check_reg(3'd1, 16'hEEBC);
        issue(3'd7, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000, 3'd0, 16'h0000, 0); wait_idle();
        check_reg(3'd5, 16'h0000);

        // Timeout: ALU never responds
        alu_mode = 1;
        issue(3'd1, 3'd3, 3'd2, 3'd2, 1'b0, 16'h0000, 3'd0, 16'h0000, 1);
        en_cnt = 0;
        while (alu_en_in && en_cnt < 50) begin
            en_cnt++;
            @(negedge clk);
        end
        check("timeout_en_cycles", 32'(en_cnt), 8);
        wait_idle();
        check("timeout_ready", 32'(instr_ready), 1);
        check_reg(3'd3, 16'h1324);
        alu_mode = 0;

        // Async reset mid-EXEC with a delayed ALU
        alu_mode  = 2;
        alu_delay = 5;
        issue(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'hABCD, 3'd0, 16'hABCD, 0);
        @(negedge clk);
        check("exec_en_in", 32'(alu_en_in), 1);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("rst_async_en_in", 32'(alu_en_in), 0);
        check("rst_async_ready", 32'(instr_ready), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) check_reg(3'(i), 16'h0000);
        repeat (8) @(negedge clk);
        check("post_rst_ready", 32'(instr_ready), 1);
        alu_mode = 0;

        // Normal operation after reset
        issue(3'd0, 3'd6, 3'd0, 3'd0, 1'b1, 16'h5A5A, 3'd0, 16'h5A5A, 0); wait_idle();
        check_reg(3'd6, 16'h5A5A);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issuing/consuming end of the datapath ALU interface. Drives en_in, alu_a, alu_b and alu_func, then waits for en_out and captures alu_out.
- Accepts 16-bit instructions over a valid/ready handshake. Reads operands from an internal 8x16 register file and writes the ALU result back.
- Sits between the instruction fetch/decode stage and the ALU.
- Strictly one instruction in flight.

Parameters:
- TIMEOUT, 8, max EXEC cycles to wait for alu_en_out before aborting (legal range 1..255)
- NREG, 8, register file depth (fixed at 8; 3-bit register addresses)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- instr_valid  input  1  instruction offered
- instr_ready  output  1  sequencer can accept an instruction
- instr  input  16  [15:13] func, [12:10] rd, [9:7] ra, [6:4] rb, [3] imm_sel, [2:0] reserved (ignored)
- instr_imm  input  16  immediate, used as operand B when imm_sel=1
- alu_en_in  output  1  to ALU en_in
- alu_a  output  16  to ALU alu_a
- alu_b  output  16  to ALU alu_b
- alu_func  output  3  to ALU alu_func (000 passB, 001 add, 010 sub, 011 and, 100 or, 101 shl1, 110 shr1)
- alu_en_out  input  1  from ALU en_out
- alu_result  input  16  from ALU alu_out
- done  output  1  one-cycle pulse on successful writeback
- wb_addr  output  3  register written (valid with done)
- wb_data  output  16  value written (valid with done)
- err  output  1  one-cycle pulse on timeout abort
- dbg_addr  input  3  debug read address
- dbg_data  output  16  combinational read of register dbg_addr (r0 reads 0)

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE.
  - All registers r0..r7 = 0.
  - Outputs: instr_ready=0 while rst=1; alu_en_in=0, alu_a=0, alu_b=0, alu_func=0, done=0, err=0, wb_addr=0, wb_data=0.
  - Reset mid-operation aborts the in-flight instruction. No writeback, no done, no err.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch func/rd/ra/rb/imm_sel/instr_imm.
  - Latch operands at the same edge: A=reg[ra]; B = imm_sel ? instr_imm : reg[rb].
  - Next state EXEC; clear the wait counter.
- EXEC:
  - instr_ready=0, alu_en_in=1.
  - alu_a/alu_b/alu_func are held from the latched values for the whole state.
  - If alu_en_out=1: capture alu_result into the result register and go to WB.
  - Else increment the counter. If it reaches TIMEOUT, go to IDLE and pulse err for one cycle (no writeback).
  - alu_en_out is sampled in EXEC only; it is ignored in IDLE and WB.
- WB:
  - alu_en_in=0.
  - Write the result to reg[rd] unless rd=0; r0 is hardwired zero and writes to it are discarded.
  - done=1 for this one cycle, with wb_addr=rd and wb_data=captured result. wb_data shows the ALU value even when rd=0.
  - Next state IDLE.
- alu_a/alu_b/alu_func hold their last values outside EXEC. Only alu_en_in qualifies them.
- Latency with a combinational ALU:
  - Accept edge N.
  - EXEC during cycle N+1.
  - done during cycle N+2; register updated at end of N+2.
  - instr_ready=1 again in cycle N+3. Sustained throughput is one instruction per 3 cycles.
- Hazards:
  - None, because the next instruction is accepted only after writeback completes.
  - Back-to-back dependent instructions read the updated value.
- Reserved func 111 is issued unchanged; the ALU returns 0, which is written back normally.
- Reserved instr bits [2:0] are ignored.
- instr_valid deasserted while ready=1: nothing happens.
- Width: all data 16 bits; no carry or overflow is tracked.
- dbg_data is purely combinational from the register array and reflects a write from the cycle after WB.

Test Plan:
- Reset then load immediates:
  - Stimulus: two instructions (func=000, rd=1, imm_sel=1, imm=0x1234), then (func=000, rd=2, imm_sel=1, imm=0x00F0).
  - Required: done pulses two cycles after each accept; dbg r1=0x1234, r2=0x00F0.
- Register-register arithmetic:
  - Stimulus: add rd=3, ra=1, rb=2, then sub rd=4, ra=2, rb=1.
  - Required: r3=0x1324; r4=0xEEBC (wrap-around).
- Shifts and logic:
  - Stimulus: shl1 rd=5, ra=1; shr1 rd=6, ra=2; and rd=7, ra=1, rb=2.
  - Required: r5=0x2468, r6=0x0078, r7=0x0030.
- r0 protection:
  - Stimulus: passB rd=0, imm=0xFFFF; then add rd=1, ra=0, rb=0.
  - Required: done with wb_data=0xFFFF; r0 reads 0; r1=0x0000.
- Timeout:
  - Stimulus: ALU model holds en_out=0, TIMEOUT=8.
  - Required: alu_en_in high for exactly 8 cycles, err pulses once, no done, rd unchanged, instr_ready returns to 1.
- Async reset mid-EXEC:
  - Stimulus: assert rst between clock edges during EXEC with a delayed-en_out ALU model.
  - Required: alu_en_in drops immediately, no done, all registers read 0 after release.
